// File: rtl/ks16_sub_pipe_pkg.sv
// Shared types and constants for the pipelined 16-bit Kogge-Stone subtractor.
// Group propagate/generate vectors travel between pipeline stages as pg_t.
package ks_pkg;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
  } pg_t;

  // Distance from each cell to its lower partner, one entry per prefix level.
  localparam int SPAN_L1 = 1;
  localparam int SPAN_L2 = 2;
  localparam int SPAN_L3 = 4;
  localparam int SPAN_L4 = 8;

endpackage

// File: rtl/ks16_sub_pipe_if.sv
// Operand/result handshake bundle for ks16_sub_pipe.
// The master drives operands and consumes results; the slave is the subtractor.
interface ks16_sub_pipe_if;
  import ks_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, neg, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, neg, ovf
  );

endinterface

// File: rtl/ks16_sub_pipe_prefix_cell.sv
// Kogge-Stone black cell: merges a high group with the adjacent lower group.
module ks_prefix_cell (
  input  logic ghi,
  input  logic phi,
  input  logic glo,
  input  logic plo,
  output logic gout,
  output logic pout
);

  assign gout = ghi | (phi & glo);
  assign pout = phi & plo;

endmodule

// File: rtl/ks16_sub_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor computing a + ~b + ~bin.
// Prefix levels 1-2 sit between stage 0 and 1, levels 3-4 between stage 1 and 2.
module ks16_sub_pipe #(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst,
  ks16_sub_pipe_if.slave bus
);
  import ks_pkg::*;

  logic             en;
  logic             v0_reg, v1_reg, v2_reg;
  pg_t              s0_reg;
  logic             cin0_reg;
  pg_t              s1_reg;
  logic [WIDTH-1:0] pc1_reg;
  logic             cin1_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg, zero_reg, neg_reg, ovf_reg;

  logic [WIDTH-1:0] l0_g;
  logic [WIDTH-1:0] l1_g, l1_p, l2_g, l2_p;
  logic [WIDTH-1:0] l3_g, l3_p, l4_g, l4_p_unused;
  logic [WIDTH-1:0] diff_next;

  // One global enable: the whole pipe moves unless a result is waiting unaccepted.
  assign en           = ~v2_reg | bus.out_ready;
  assign bus.in_ready = en;

  // Carry-in folded into bit 0 so every group G below becomes a true carry.
  always_comb begin
    l0_g    = s0_reg.g;
    l0_g[0] = s0_reg.g[0] | (s0_reg.p[0] & cin0_reg);
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lvl1
      if (gi >= SPAN_L1) begin : g_cell
        ks_prefix_cell u_cell (
          .ghi(l0_g[gi]), .phi(s0_reg.p[gi]),
          .glo(l0_g[gi-SPAN_L1]), .plo(s0_reg.p[gi-SPAN_L1]),
          .gout(l1_g[gi]), .pout(l1_p[gi])
        );
      end else begin : g_pass
        assign l1_g[gi] = l0_g[gi];
        assign l1_p[gi] = s0_reg.p[gi];
      end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lvl2
      if (gi >= SPAN_L2) begin : g_cell
        ks_prefix_cell u_cell (
          .ghi(l1_g[gi]), .phi(l1_p[gi]),
          .glo(l1_g[gi-SPAN_L2]), .plo(l1_p[gi-SPAN_L2]),
          .gout(l2_g[gi]), .pout(l2_p[gi])
        );
      end else begin : g_pass
        assign l2_g[gi] = l1_g[gi];
        assign l2_p[gi] = l1_p[gi];
      end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lvl3
      if (gi >= SPAN_L3) begin : g_cell
        ks_prefix_cell u_cell (
          .ghi(s1_reg.g[gi]), .phi(s1_reg.p[gi]),
          .glo(s1_reg.g[gi-SPAN_L3]), .plo(s1_reg.p[gi-SPAN_L3]),
          .gout(l3_g[gi]), .pout(l3_p[gi])
        );
      end else begin : g_pass
        assign l3_g[gi] = s1_reg.g[gi];
        assign l3_p[gi] = s1_reg.p[gi];
      end
    end

    // Final group propagate is not needed; only the carries leave this level.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lvl4
      if (gi >= SPAN_L4) begin : g_cell
        ks_prefix_cell u_cell (
          .ghi(l3_g[gi]), .phi(l3_p[gi]),
          .glo(l3_g[gi-SPAN_L4]), .plo(l3_p[gi-SPAN_L4]),
          .gout(l4_g[gi]), .pout(l4_p_unused[gi])
        );
      end else begin : g_pass
        assign l4_g[gi]        = l3_g[gi];
        assign l4_p_unused[gi] = l3_p[gi];
      end
    end
  endgenerate

  assign diff_next = pc1_reg ^ {l4_g[WIDTH-2:0], cin1_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_reg   <= 1'b0;
      v1_reg   <= 1'b0;
      v2_reg   <= 1'b0;
      diff_reg <= '0;
      bout_reg <= 1'b0;
      zero_reg <= 1'b0;
      neg_reg  <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (en) begin
      v0_reg   <= bus.in_valid;
      v1_reg   <= v0_reg;
      v2_reg   <= v1_reg;
      s0_reg   <= '{p: bus.a ^ ~bus.b, g: bus.a & ~bus.b};
      cin0_reg <= ~bus.bin;
      s1_reg   <= '{p: l2_p, g: l2_g};
      pc1_reg  <= s0_reg.p;
      cin1_reg <= cin0_reg;
      // Bubbles present zeroed results so idle outputs never show stale data.
      if (v1_reg) begin
        diff_reg <= diff_next;
        bout_reg <= ~l4_g[WIDTH-1];
        zero_reg <= (diff_next == '0);
        neg_reg  <= diff_next[WIDTH-1];
        ovf_reg  <= l4_g[WIDTH-1] ^ l4_g[WIDTH-2];
      end else begin
        diff_reg <= '0;
        bout_reg <= 1'b0;
        zero_reg <= 1'b0;
        neg_reg  <= 1'b0;
        ovf_reg  <= 1'b0;
      end
    end
  end

  assign bus.out_valid = v2_reg;
  assign bus.diff      = diff_reg;
  assign bus.bout      = bout_reg;
  assign bus.zero      = zero_reg;
  assign bus.neg       = neg_reg;
  assign bus.ovf       = ovf_reg;

endmodule
